// File: rtl/snn_psum_accumulator.sv
// Receive-side partial-sum accumulator: integrates PE psum packets into per-neuron
// membrane potentials, thresholds each completed row and hands the spike row downstream.
module snn_psum_accumulator #(
  parameter int WIDTH_O        = 13,
  parameter int ADDR_WIDTH     = 5,
  parameter int OUT_DIM        = 21,
  parameter int NUM_PARTIAL    = 5,
  parameter int MEM_WIDTH      = 16,
  parameter int THRESHOLD      = 64,
  parameter int PACKET_D_WIDTH = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [PACKET_D_WIDTH-1:0] psum_data,
  output logic                      spike_valid,
  input  logic                      spike_ready,
  output logic [OUT_DIM-1:0]        spike_data,
  output logic [ADDR_WIDTH-1:0]     spike_row,
  output logic                      ts_done,
  output logic                      err_sticky,
  output logic [1:0]                fsm_state
);

  localparam int RSV_W     = PACKET_D_WIDTH - 2 * ADDR_WIDTH - WIDTH_O;
  localparam int ROW_CNT_W = $clog2(OUT_DIM * NUM_PARTIAL + 1);

  localparam logic [ADDR_WIDTH-1:0] DIM_A     = ADDR_WIDTH'(OUT_DIM);
  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(OUT_DIM - 1);
  localparam logic [ROW_CNT_W-1:0]  ROW_FULL  = ROW_CNT_W'(OUT_DIM * NUM_PARTIAL);
  localparam logic [MEM_WIDTH-1:0]  THRESH    = MEM_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {ACCUM = 2'd0, FIRE = 2'd1, SEND = 2'd2} state_t;

  state_t state, state_next;

  logic [MEM_WIDTH-1:0]  membrane [OUT_DIM][OUT_DIM];
  logic [ROW_CNT_W-1:0]  row_cnt  [OUT_DIM];
  logic [ADDR_WIDTH-1:0] rows_emitted;
  logic [ADDR_WIDTH-1:0] fire_row;
  logic [ADDR_WIDTH-1:0] fire_col;
  logic [OUT_DIM-1:0]    spike_bits;

  // Handshakes: a psum packet transfers on a cycle where psum_valid && psum_ready; a spike
  // row transfers on a cycle where spike_valid && spike_ready, and spike_data/spike_row hold
  // steady from the first spike_valid cycle until that transfer.
  logic accept;
  assign psum_ready  = (state == ACCUM) && !reset;
  assign accept      = psum_valid && psum_ready;
  assign spike_valid = (state == SEND);
  assign spike_data  = spike_bits;
  assign spike_row   = fire_row;
  assign fsm_state   = state;

  logic [ADDR_WIDTH-1:0] pkt_row, pkt_col;
  logic [RSV_W-1:0]      pkt_rsv;
  logic [WIDTH_O-1:0]    pkt_psum;
  logic                  malformed;

  assign pkt_row   = psum_data[PACKET_D_WIDTH-1 -: ADDR_WIDTH];
  assign pkt_col   = psum_data[PACKET_D_WIDTH-ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign pkt_rsv   = psum_data[PACKET_D_WIDTH-2*ADDR_WIDTH-1 -: RSV_W];
  assign pkt_psum  = psum_data[WIDTH_O-1:0];
  assign malformed = (|pkt_rsv) || (pkt_row >= DIM_A) || (pkt_col >= DIM_A);

  // The membrane register is written on the accept edge, so a repeated hit on the same
  // neuron in the next cycle already reads the updated value.
  logic [MEM_WIDTH-1:0] acc_cur, acc_sat;
  logic [MEM_WIDTH:0]   acc_sum;
  logic [ROW_CNT_W-1:0] row_cnt_inc;
  logic                 row_done;

  assign acc_cur     = membrane[pkt_row][pkt_col];
  assign acc_sum     = (MEM_WIDTH+1)'(acc_cur) + (MEM_WIDTH+1)'(pkt_psum);
  assign acc_sat     = acc_sum[MEM_WIDTH] ? '1 : acc_sum[MEM_WIDTH-1:0];
  assign row_cnt_inc = row_cnt[pkt_row] + 1'b1;
  assign row_done    = accept && !malformed && (row_cnt_inc == ROW_FULL);

  logic [MEM_WIDTH-1:0] fire_mem;
  logic                 fire_hit;
  assign fire_mem = membrane[fire_row][fire_col];
  assign fire_hit = (fire_mem >= THRESH);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (row_done) state_next = FIRE;
      FIRE:    if (fire_col == LAST_A) state_next = SEND;
      SEND:    if (spike_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ACCUM;
      rows_emitted <= '0;
      fire_row     <= '0;
      fire_col     <= '0;
      spike_bits   <= '0;
      ts_done      <= 1'b0;
      err_sticky   <= 1'b0;
      for (int i = 0; i < OUT_DIM; i++) begin
        row_cnt[i] <= '0;
        for (int j = 0; j < OUT_DIM; j++) membrane[i][j] <= '0;
      end
    end else begin
      state   <= state_next;
      ts_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (accept) begin
            if (malformed) begin
              err_sticky <= 1'b1;
            end else begin
              membrane[pkt_row][pkt_col] <= acc_sat;
              row_cnt[pkt_row]           <= row_cnt_inc;
              if (row_done) begin
                fire_row <= pkt_row;
                fire_col <= '0;
              end
            end
          end
        end
        FIRE: begin
          // Reset-by-subtraction keeps the residual above threshold for the next timestep.
          spike_bits[fire_col] <= fire_hit;
          if (fire_hit) membrane[fire_row][fire_col] <= fire_mem - THRESH;
          fire_col <= fire_col + 1'b1;
        end
        SEND: begin
          if (spike_ready) begin
            row_cnt[fire_row] <= '0;
            if (rows_emitted == LAST_A) begin
              rows_emitted <= '0;
              ts_done      <= 1'b1;
            end else begin
              rows_emitted <= rows_emitted + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_psum_accumulator.sv
// Bench for snn_psum_accumulator: directed and randomized psum streams checked against a
// per-neuron arithmetic model of accumulate / threshold / reset-by-subtraction.
module tb_snn_psum_accumulator;

  localparam int DIM   = 21;
  localparam int NPART = 5;
  localparam int THR   = 64;
  localparam int MAXM  = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        psum_valid;
  logic        psum_ready;
  logic [39:0] psum_data;
  logic        spike_valid;
  logic        spike_ready;
  logic [20:0] spike_data;
  logic [4:0]  spike_row;
  logic        ts_done;
  logic        err_sticky;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  snn_psum_accumulator dut (
    .clk(clk), .reset(reset), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_data(spike_data), .spike_row(spike_row), .ts_done(ts_done),
    .err_sticky(err_sticky), .fsm_state(fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  int         m_mem [DIM][DIM];
  int         m_cnt [DIM];
  int         m_emitted;
  logic [25:0] exp_q[$];
  int         stall_cycles = 0;
  bit         skip_fire = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DIM; i++) begin
      m_cnt[i] = 0;
      for (int j = 0; j < DIM; j++) m_mem[i][j] = 0;
    end
    m_emitted = 0;
    exp_q.delete();
  endtask

  task automatic model_fire(input int r);
    logic [20:0] b;
    b = '0;
    for (int c = 0; c < DIM; c++) begin
      if (m_mem[r][c] >= THR) begin
        b[c] = 1'b1;
        m_mem[r][c] -= THR;
      end
    end
    m_cnt[r] = 0;
    exp_q.push_back({5'(r), b});
  endtask

  task automatic check_row(input string tag, input int r);
    int bad;
    bad = 0;
    for (int c = 0; c < DIM; c++)
      if (int'(dut.membrane[r][c]) != m_mem[r][c]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic check_storage(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < DIM; r++) begin
      if (int'(dut.row_cnt[r]) != m_cnt[r]) bad++;
      for (int c = 0; c < DIM; c++)
        if (int'(dut.membrane[r][c]) != m_mem[r][c]) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    psum_valid  = 1'b0;
    psum_data   = '0;
    spike_ready = 1'b1;
    tick();
    check("reset_ready_low", 64'(psum_ready), 64'd0);
    check("reset_outputs", 64'({spike_valid, spike_data, spike_row, ts_done, err_sticky, fsm_state}), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(psum_ready), 64'd1);
    model_clear();
  endtask

  // Called one cycle after the completing packet was accepted (first FIRE cycle).
  task automatic check_fire();
    logic [25:0] e;
    int          n;
    bit          exp_ts;
    int          r;
    e = exp_q.pop_front();
    r = int'(e[25:21]);
    spike_ready = (stall_cycles == 0);
    n = 0;
    while (!spike_valid && n < 100) begin
      tick();
      n++;
    end
    check("fire_latency", 64'(n), 64'(DIM));
    check("spike_row", 64'(spike_row), 64'(e[25:21]));
    check("spike_data", 64'(spike_data), 64'(e[20:0]));
    check("send_ready_low", 64'(psum_ready), 64'd0);
    if (stall_cycles > 0) begin
      psum_data  = {5'd11, 5'd0, 17'd0, 13'd5};
      psum_valid = 1'b1;
      for (int i = 0; i < stall_cycles; i++) begin
        tick();
        check("stall_hold", 64'({spike_valid, psum_ready, spike_row, spike_data}),
              64'({1'b1, 1'b0, e}));
      end
      spike_ready = 1'b1;
    end
    tick();
    m_emitted++;
    exp_ts = (m_emitted == DIM);
    if (exp_ts) m_emitted = 0;
    check("ts_done", 64'(ts_done), 64'(exp_ts));
    check("ready_back", 64'({psum_ready, spike_valid}), 64'b10);
    check_row("fired_row_membrane", r);
    if (stall_cycles > 0) begin
      tick();
      psum_valid = 1'b0;
      m_mem[11][0] = (m_mem[11][0] + 5 > MAXM) ? MAXM : m_mem[11][0] + 5;
      m_cnt[11]++;
      check("stalled_pkt_consumed", 64'(dut.membrane[11][0]), 64'(m_mem[11][0]));
      stall_cycles = 0;
    end
  endtask

  task automatic send_pkt(input logic [4:0] row, input logic [4:0] col,
                          input logic [12:0] psum, input logic [16:0] rsv);
    int n;
    int r, c;
    psum_data  = {row, col, rsv, psum};
    psum_valid = 1'b1;
    n = 0;
    while (!psum_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
    tick();
    psum_valid = 1'b0;
    r = int'(row);
    c = int'(col);
    if (rsv != 0 || r >= DIM || c >= DIM) return;
    m_mem[r][c] = (m_mem[r][c] + int'(psum) > MAXM) ? MAXM : m_mem[r][c] + int'(psum);
    m_cnt[r]++;
    if (m_cnt[r] == DIM * NPART) begin
      model_fire(r);
      if (!skip_fire) check_fire();
    end
  endtask

  task automatic feed_row_random(input int r, input int hi);
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) begin
        if ($urandom_range(0, 5) == 0) tick();
        send_pkt(5'(r), 5'(c), 13'($urandom_range(0, hi)), 17'd0);
      end
  endtask

  int vals63 [NPART] = '{12, 12, 13, 13, 13};

  initial begin
    do_reset();
    check_storage("reset_storage");

    // Row 0: five packets of 20 per column -> all fire, residual 36.
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) send_pkt(5'd0, 5'(c), 13'd20, 17'd0);
    check("row0_residual", 64'(dut.membrane[0][7]), 64'd36);

    // Row 3: column 5 just below threshold, then one more unit next timestep.
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) send_pkt(5'd3, 5'(c), (c == 5) ? 13'(vals63[p]) : 13'd0, 17'd0);
    check("row3_below_thr", 64'(dut.membrane[3][5]), 64'd63);
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) send_pkt(5'd3, 5'(c), (c == 5 && p == 0) ? 13'd1 : 13'd0, 17'd0);
    check("row3_residual", 64'(dut.membrane[3][5]), 64'd0);

    // Malformed packets: reserved bit 20, row 21, col 25.
    check("err_clear", 64'(err_sticky), 64'd0);
    send_pkt(5'd5, 5'd2, 13'd7, 17'h00080);
    send_pkt(5'd21, 5'd0, 13'd9, 17'd0);
    send_pkt(5'd2, 5'd25, 13'd9, 17'd0);
    check("err_set", 64'(err_sticky), 64'd1);
    check_storage("malformed_no_change");
    feed_row_random(7, 25);
    check("err_still_set", 64'(err_sticky), 64'd1);

    // Backpressure on the spike port while a psum packet waits.
    stall_cycles = 10;
    feed_row_random(12, 25);
    check_storage("after_stall");

    // Saturation of one neuron.
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) send_pkt(5'd9, 5'(c), (c == 2) ? 13'd8191 : 13'd0, 17'd0);
    for (int p = 0; p < NPART; p++) send_pkt(5'd9, 5'd2, 13'd8191, 17'd0);
    check("saturate_65535", 64'(dut.membrane[9][2]), 64'd65535);
    for (int c = 0; c < DIM; c++)
      if (c != 2)
        for (int p = 0; p < NPART; p++) send_pkt(5'd9, 5'(c), 13'd0, 17'd0);
    check("saturate_residual", 64'(dut.membrane[9][2]), 64'd65471);

    // Reset in the middle of FIRE discards everything.
    skip_fire = 1'b1;
    for (int c = 0; c < DIM; c++)
      for (int p = 0; p < NPART; p++) send_pkt(5'd4, 5'(c), 13'd20, 17'd0);
    skip_fire = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("in_fire", 64'(psum_ready), 64'd0);
    do_reset();
    check_storage("reset_in_fire_storage");

    // All rows, randomly interleaved, completing in order 20 down to 0.
    for (int s = 0; s < DIM * NPART - 1; s++) begin
      int off;
      off = $urandom_range(0, DIM - 1);
      for (int i = 0; i < DIM; i++) begin
        if ($urandom_range(0, 7) == 0) tick();
        send_pkt(5'((i + off) % DIM), 5'(s % DIM), 13'($urandom_range(0, 25)), 17'd0);
      end
    end
    for (int r = DIM - 1; r >= 0; r--)
      send_pkt(5'(r), 5'(DIM - 1), 13'($urandom_range(0, 25)), 17'd0);
    tick();
    check("ts_done_one_cycle", 64'(ts_done), 64'd0);
    check_storage("final_storage");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
